// File: rtl/puf_challenge_sequencer.sv
// Steps PUF challenges from a seed, settles, majority-votes VOTES samples per challenge and packs a KEY_W-bit key.
// Key valid C*(SETTLE+VOTES) edges after start; key held on key_valid until key_ready, start ignored while busy.
module puf_challenge_sequencer #(
  parameter int N      = 4,
  parameter int M      = 1,
  parameter int KEY_W  = 16,
  parameter int SETTLE = 4,
  parameter int VOTES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     seed,
  output logic [N-1:0]     challenge,
  input  logic [M-1:0]     response,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             busy
);

  localparam int C  = KEY_W / M;
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int CW = $clog2(VOTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SW-1:0]       r_settle_cnt;
  logic [VW-1:0]       r_vote_idx;
  logic [IW-1:0]       r_index;
  logic [M-1:0][CW-1:0] r_votes;
  logic [M-1:0][CW-1:0] w_tot;
  logic [M-1:0]        w_voted;
  logic                w_last_settle;
  logic                w_last_vote;
  logic                w_last_chal;

  assign w_last_settle = (r_settle_cnt == SW'(SETTLE - 1));
  assign w_last_vote   = (r_vote_idx == VW'(VOTES - 1));
  assign w_last_chal   = (r_index == IW'(C - 1));

  // The sample taken on the final vote edge is folded into the total before deciding.
  always_comb begin
    w_tot   = '0;
    w_voted = '0;
    for (int j = 0; j < M; j++) begin
      w_tot[j]   = r_votes[j] + CW'(response[j]);
      w_voted[j] = (w_tot[j] > CW'(VOTES / 2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (w_last_settle) w_next = S_SAMPLE;
      S_SAMPLE: if (w_last_vote) w_next = w_last_chal ? S_DONE : S_SETTLE;
      S_DONE:   if (key_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    key_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      challenge    <= '0;
      key_out      <= '0;
      r_index      <= '0;
      r_settle_cnt <= '0;
      r_vote_idx   <= '0;
      r_votes      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            challenge    <= seed;
            key_out      <= '0;
            r_index      <= '0;
            r_settle_cnt <= '0;
            r_vote_idx   <= '0;
            r_votes      <= '0;
          end
        end
        S_SETTLE: begin
          r_settle_cnt <= w_last_settle ? '0 : r_settle_cnt + SW'(1);
          r_vote_idx   <= '0;
        end
        S_SAMPLE: begin
          if (w_last_vote) begin
            for (int i = 0; i < C; i++) begin
              if (r_index == IW'(i)) key_out[i*M +: M] <= w_voted;
            end
            r_votes    <= '0;
            r_vote_idx <= '0;
            if (!w_last_chal) begin
              r_index   <= r_index + IW'(1);
              challenge <= challenge + N'(1);
            end
          end else begin
            r_votes    <= w_tot;
            r_vote_idx <= r_vote_idx + VW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with a behavioural PUF whose response can inject vote noise.
module tb_puf_challenge_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  seed;
  logic [3:0]  challenge;
  logic [0:0]  response;
  logic [15:0] key_out;
  logic        key_valid;
  logic        key_ready;
  logic        busy;

  always #5 clk = ~clk;

  puf_challenge_sequencer #(
    .N(4), .M(1), .KEY_W(16), .SETTLE(4), .VOTES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .challenge(challenge), .response(response),
    .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready), .busy(busy)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] sb[$];
  logic [3:0]  chal_log[$];
  int          mode = 0;
  int          ph = 0;
  int          stab_err = 0;
  logic [3:0]  prev_chal = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Phase within a challenge window: 0..3 settle cycles, 4..6 sample cycles.
  always @(posedge clk) begin
    if (!busy) ph <= 0;
    else       ph <= (ph == 6) ? 0 : ph + 1;
  end

  always_comb begin
    case (mode)
      0:       response = challenge[0];
      1:       response = (ph < 4) ? 1'b1 : ((ph == 4 + int'(challenge % 3)) ? 1'b1 : 1'b0);
      2:       response = (ph < 4) ? 1'b1 : ((!challenge[0] && ph != 6) ? 1'b1 : 1'b0);
      default: response = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (busy) begin
      if (ph == 4) chal_log.push_back(challenge);
      if (ph != 0 && challenge !== prev_chal) stab_err++;
    end
    prev_chal = challenge;
  end

  task automatic pulse_start(input logic [3:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!key_valid && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic sb_check(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, key_out, e);
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    key_ready = 1'b1;
    sb_check({tag, "_key"});
    @(posedge clk);
    #1;
    chk({tag, "_kv_after"}, key_valid, 0);
    chk({tag, "_busy_after"}, busy, 0);
    key_ready = 1'b0;
  endtask

  task automatic run_key(input logic [3:0] s, input int md, input logic [15:0] exp, input string tag);
    int n;
    logic [3:0] e;
    mode = md;
    chal_log.delete();
    stab_err = 0;
    sb.push_back(exp);
    pulse_start(s);
    wait_valid(n);
    chk({tag, "_latency"}, n, 112);
    chk({tag, "_nchal"}, chal_log.size(), 16);
    for (int i = 0; i < 16 && i < chal_log.size(); i++) begin
      e = s + 4'(i);
      chk({tag, "_chal"}, chal_log[i], e);
    end
    chk({tag, "_chal_stable"}, stab_err, 0);
    handshake(tag);
  endtask

  initial begin
    int n;
    int bad;
    logic [15:0] k0;
    rst = 1'b1; start = 1'b0; seed = '0; key_ready = 1'b0;
    #12;
    chk("rst_challenge", challenge, 0);
    chk("rst_key_out", key_out, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;

    run_key(4'h0, 0, 16'hAAAA, "seed0");
    run_key(4'hF, 0, 16'h5555, "seedF");
    run_key(4'h0, 1, 16'h0000, "maj1");
    run_key(4'h0, 2, 16'h5555, "maj2");

    // Backpressure with a start pulse during the stall
    mode = 0;
    sb.push_back(16'hAAAA);
    pulse_start(4'h0);
    wait_valid(n);
    chk("bp_latency", n, 112);
    k0 = key_out;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 8) begin seed = 4'h5; start = 1'b1; end
      if (c == 9) start = 1'b0;
      if (key_valid !== 1'b1 || key_out !== k0) bad++;
    end
    chk("bp_stable", bad, 0);
    handshake("bp");

    // Asynchronous reset mid-run
    sb.push_back(16'hAAAA);
    pulse_start(4'h0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_challenge", challenge, 0);
    chk("mrst_key_out", key_out, 0);
    chk("mrst_key_valid", key_valid, 0);
    chk("mrst_busy", busy, 0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    run_key(4'h0, 0, 16'hAAAA, "post_rst");

    // start held high, key_ready held high: back-to-back runs
    seed = 4'h0;
    key_ready = 1'b1;
    for (int r = 0; r < 3; r++) sb.push_back(16'hAAAA);
    @(negedge clk) start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!key_valid && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_valid_seen", key_valid, 1);
      sb_check("b2b_key");
      @(negedge clk);
      chk("b2b_valid_width", key_valid, 0);
      chk("b2b_idle_gap", busy, 0);
      @(negedge clk);
      chk("b2b_restart", busy, 1);
    end
    start = 1'b0;
    key_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
